// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, a single-entry
// output buffer, flush/redirect handling and a synthetic NOP for misaligned pcs.
module instr_fetch #(
    parameter logic [31:0] ERR_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_err,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic        accept;
    logic        aligned;
    logic        load_rsp;
    logic        load_err;

    assign pc_ready  = (state_q == IDLE) && (!instr_valid || instr_ready) && !flush;
    assign accept    = pc_valid && pc_ready;
    assign aligned   = (pc[1:0] == 2'b00);
    assign load_err  = accept && !aligned;
    assign imem_req  = (state_q == REQ);
    assign imem_addr = addr_q;

    always_comb begin
        state_d  = state_q;
        load_rsp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && aligned) state_d = REQ;
            end
            REQ: begin
                // A grant in the flush cycle still leaves a response in flight.
                if (flush)         state_d = imem_gnt ? DRAIN : IDLE;
                else if (imem_gnt) state_d = RESP;
            end
            RESP: begin
                if (imem_rvalid) begin
                    state_d  = IDLE;
                    load_rsp = !flush;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every clocked register uses non-blocking assignment so all state
    // updates see the pre-edge values, whatever the block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept && aligned) addr_q <= pc;
        end
    end

    // Output buffer: flush beats any load, and a load beats consumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_err   <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (load_rsp) begin
            instr_valid <= 1'b1;
            instr       <= imem_rdata;
            instr_pc    <= addr_q;
            instr_err   <= 1'b0;
        end else if (load_err) begin
            instr_valid <= 1'b1;
            instr       <= ERR_INSTR;
            instr_pc    <= pc;
            instr_err   <= 1'b1;
        end else if (instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule
